// File: rtl/conv_job_dispatcher.sv
// conv_job_dispatcher: queues X/Y/Z jobs in a FIFO and launches them one at a time into the engine (start pulse, wait done rise or watchdog); reports pending, jobs_done, sticky timeout
module conv_job_dispatcher #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_y,
  input  logic [DATA_W-1:0] in_z,
  output logic [DATA_W-1:0] X,
  output logic [DATA_W-1:0] Y,
  output logic [DATA_W-1:0] Z,
  output logic              start,
  input  logic              done,
  output logic              busy,
  output logic [ADDR_W:0]   pending,
  output logic [7:0]        jobs_done,
  output logic              timeout
);
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;
  state_t state;
  logic [3*DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0] count;
  logic [WD_W-1:0] wdog;
  logic done_q, push, pop, done_rise;
  assign in_ready  = count < (ADDR_W+1)'(DEPTH);
  assign push      = in_valid && in_ready;
  assign pop       = state == IDLE && count != '0;
  assign done_rise = done && !done_q;
  assign pending   = count;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_x, in_y, in_z};
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wdog      <= '0;
      done_q    <= 1'b0;
      X         <= '0;
      Y         <= '0;
      Z         <= '0;
      start     <= 1'b0;
      busy      <= 1'b0;
      jobs_done <= '0;
      timeout   <= 1'b0;
    end else begin
      done_q <= done;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      case (state)
        IDLE: if (pop) begin
          {X, Y, Z} <= mem[rd_ptr];
          start     <= 1'b1;
          busy      <= 1'b1;
          state     <= LAUNCH;
        end
        LAUNCH: begin
          start <= 1'b0;
          wdog  <= '0;
          state <= RUN;
        end
        RUN: if (done_rise) begin
          state     <= IDLE;
          busy      <= 1'b0;
          jobs_done <= jobs_done + 8'd1;
        end else if (wdog == WD_W'(TIMEOUT - 1)) begin
          timeout <= 1'b1;
          state   <= IDLE;
          busy    <= 1'b0;
        end else wdog <= wdog + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
